// File: rtl/shift_sched_pkg.sv
// Shared constants for the shift scheduler: FSM encodings, per-pass shift
// limit and the default operand/shift-amount widths.
package shift_sched_pkg;

    localparam int OPERAND_WIDTH_DEF = 16;
    localparam int SHAMT_WIDTH_DEF   = 5;

    // The barrel shifter takes a 4-bit amount, so one pass moves at most 15 bits.
    localparam int               PASS_W   = 4;
    localparam logic [PASS_W-1:0] MAX_PASS = 4'd15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_right_arthimetic.sv
// Combinational arithmetic-right barrel shifter; vacated bits take the
// operand's sign bit.
module shift_right_arthimetic
    import shift_sched_pkg::*;
#(
    parameter int WIDTH     = OPERAND_WIDTH_DEF,
    parameter int AMT_WIDTH = PASS_W
) (
    input  logic [WIDTH-1:0]     operand,
    input  logic [AMT_WIDTH-1:0] amount,
    output logic [WIDTH-1:0]     result
);

    logic signed [WIDTH-1:0] operand_s;
    logic signed [WIDTH-1:0] result_s;

    assign operand_s = operand;
    assign result_s  = operand_s >>> amount;
    assign result    = result_s;

endmodule

// File: rtl/shift_sched.sv
// Two-requester round-robin scheduler feeding a multi-pass arithmetic right
// shifter; one operation in flight, result held until the consumer takes it.
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF,
    parameter int SHAMT_WIDTH   = SHAMT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [OPERAND_WIDTH-1:0] req0_data,
    input  logic [SHAMT_WIDTH-1:0]   req0_shamt,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [OPERAND_WIDTH-1:0] req1_data,
    input  logic [SHAMT_WIDTH-1:0]   req1_shamt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] out_data,
    output logic                     out_id,
    output logic                     busy
);

    logic [1:0]               state;
    logic [OPERAND_WIDTH-1:0] opnd;
    logic [SHAMT_WIDTH-1:0]   remaining;
    logic                     id;
    logic                     last;

    logic                     grant_any;
    logic                     grant_id;
    logic [PASS_W-1:0]        pass;
    logic [SHAMT_WIDTH-1:0]   remaining_next;
    logic [OPERAND_WIDTH-1:0] shifted;

    // With both requesters valid, the one not granted last wins.
    always_comb begin
        grant_any = (state == ST_IDLE) && (req0_valid || req1_valid);
        grant_id  = (req0_valid && req1_valid) ? ~last : req1_valid;
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any &&  grant_id;

    assign pass           = (remaining > SHAMT_WIDTH'(MAX_PASS)) ? MAX_PASS
                                                                 : remaining[PASS_W-1:0];
    assign remaining_next = remaining - SHAMT_WIDTH'(pass);

    shift_right_arthimetic #(
        .WIDTH     (OPERAND_WIDTH),
        .AMT_WIDTH (PASS_W)
    ) u_shifter (
        .operand (opnd),
        .amount  (pass),
        .result  (shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            opnd      <= '0;
            remaining <= '0;
            id        <= 1'b0;
            last      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        opnd      <= grant_id ? req1_data  : req0_data;
                        remaining <= grant_id ? req1_shamt : req0_shamt;
                        id        <= grant_id;
                        last      <= grant_id;
                        state     <= ST_SHIFT;
                    end
                end
                // A zero shift amount still spends one pass here.
                ST_SHIFT: begin
                    opnd      <= shifted;
                    remaining <= remaining_next;
                    if (remaining_next == '0) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (state == ST_DONE);
    assign out_data  = opnd;
    assign out_id    = id;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// Randomized and directed bench for shift_sched against a transaction-level
// latency/arbitration model.
module tb_shift_sched;

    logic        clk;
    logic        rst;
    logic        v0, v1, ordy;
    logic [15:0] d0, d1;
    logic [4:0]  s0, s1;
    logic        req0_ready, req1_ready, out_valid, out_id, busy;
    logic [15:0] out_data;

    shift_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0),
        .req0_ready (req0_ready),
        .req0_data  (d0),
        .req0_shamt (s0),
        .req1_valid (v1),
        .req1_ready (req1_ready),
        .req1_data  (d1),
        .req1_shamt (s1),
        .out_valid  (out_valid),
        .out_ready  (ordy),
        .out_data   (out_data),
        .out_id     (out_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an operation is in flight from grant until handshake,
    // and its result is visible from cycle done_at onwards.
    bit          m_inflight = 0;
    bit          m_last     = 1;
    bit          m_id       = 0;
    logic [15:0] m_data     = '0;
    int          m_done_at  = 0;
    int          cyc        = 0;
    int          glog[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int passes(input logic [4:0] s);
        int si;
        si = int'(s);
        return (si == 0) ? 1 : (si + 14) / 15;
    endfunction

    function automatic logic [15:0] ashr(input logic [15:0] d, input logic [4:0] s);
        logic signed [15:0] sd;
        sd = d;
        return sd >>> s;
    endfunction

    // Checks one cycle with the currently driven inputs, then advances.
    task automatic cycle();
        bit g_any, g_id, ov;
        #1;
        g_any = !m_inflight && (v0 || v1);
        g_id  = (v0 && v1) ? !m_last : v1;
        ov    = m_inflight && (cyc >= m_done_at);
        if (!rst) begin
            check("rdy0", req0_ready, g_any && !g_id);
            check("rdy1", req1_ready, g_any && g_id);
            check("busy", busy, m_inflight);
            check("ovld", out_valid, ov);
            if (ov) begin
                check("odata", out_data, m_data);
                check("oid", out_id, m_id);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_inflight = 0;
            m_last     = 1;
        end else if (g_any) begin
            m_inflight = 1;
            m_last     = g_id;
            m_id       = g_id;
            m_data     = g_id ? ashr(d1, s1) : ashr(d0, s0);
            m_done_at  = cyc + (g_id ? passes(s1) : passes(s0));
            glog.push_back(int'(g_id));
            if (g_id) v1 = 1'b0; else v0 = 1'b0;
        end else if (ov && ordy) begin
            m_inflight = 0;
        end
    endtask

    task automatic do_reset();
        v0 = 0; v1 = 0; ordy = 0;
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    task automatic drain();
        int n;
        v0 = 0; v1 = 0; ordy = 1;
        n = 0;
        while (m_inflight && n < 10) begin
            cycle();
            n++;
        end
        check("drain_timeout", m_inflight, 0);
    endtask

    // Issue one req0 operation, count SHIFT cycles, leave DONE pending.
    task automatic run_one(input string tag, input logic [15:0] d, input logic [4:0] s,
                           input logic [15:0] exp, input int exp_passes);
        int n;
        v0 = 1; d0 = d; s0 = s; ordy = 0;
        cycle();
        n = 0;
        while (!out_valid && n < 10) begin
            n++;
            cycle();
        end
        check({tag, "_passes"}, n, exp_passes);
        check({tag, "_data"}, out_data, exp);
    endtask

    function automatic logic [4:0] rand_shamt();
        logic [4:0] edges [8] = '{5'd0, 5'd1, 5'd14, 5'd15, 5'd16, 5'd29, 5'd30, 5'd31};
        if ($urandom_range(1, 0) == 1) return edges[$urandom_range(7, 0)];
        return 5'($urandom_range(31, 0));
    endfunction

    initial begin
        logic [15:0] held_d;
        logic        held_id;
        bit          seen;
        int          n;

        rst = 1; v0 = 0; v1 = 0; ordy = 0;
        d0 = '0; d1 = '0; s0 = '0; s1 = '0;
        do_reset();
        check("rst_ovld", out_valid, 0);
        check("rst_odata", out_data, 0);
        check("rst_oid", out_id, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);

        // Single request: 0x8001 >>> 1, result two cycles after grant.
        v0 = 1; d0 = 16'h8001; s0 = 5'd1; ordy = 0;
        #1;
        check("d1_rdy0", req0_ready, 1);
        cycle();
        check("d1_notyet", out_valid, 0);
        cycle();
        check("d1_ovld", out_valid, 1);
        check("d1_data", out_data, 16'hC000);
        check("d1_id", out_id, 0);
        drain();

        // Contention: req0, req1, req0.
        do_reset();
        glog.delete();
        v0 = 1; d0 = 16'h1234; s0 = 5'd0;
        v1 = 1; d1 = 16'h7FF0; s1 = 5'd4;
        ordy = 1;
        seen = 0;
        n = 0;
        while (glog.size() < 3 && n < 40) begin
            if (!v0 && glog.size() < 2) begin
                v0 = 1; d0 = 16'h0100; s0 = 5'd2;
            end
            cycle();
            if (out_valid && out_id) begin
                check("rr_d1", out_data, 16'h07FF);
                seen = 1;
            end
            n++;
        end
        drain();
        check("rr_seen", seen, 1);
        check("rr_count", glog.size(), 3);
        if (glog.size() == 3) begin
            check("rr_g0", glog[0], 0);
            check("rr_g1", glog[1], 1);
            check("rr_g2", glog[2], 0);
        end

        run_one("s31", 16'h8000, 5'd31, 16'hFFFF, 3);
        drain();
        run_one("s16", 16'h4000, 5'd16, 16'h0000, 2);
        drain();

        // Stall in DONE with both requesters waiting.
        run_one("hold", 16'hB3C5, 5'd7, 16'hFF67, 1);
        held_d  = out_data;
        held_id = out_id;
        v1 = 1; d1 = 16'h1111; s1 = 5'd3;
        v0 = 1; d0 = 16'h2222; s0 = 5'd5;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("hold_data", out_data, held_d);
            check("hold_id", out_id, held_id);
        end
        v0 = 0; v1 = 0; ordy = 1;
        cycle();
        check("hold_idle", busy, 0);
        drain();

        // Reset while shifting, then contention goes to req0.
        v0 = 1; d0 = 16'h8000; s0 = 5'd31; ordy = 0;
        cycle();
        cycle();
        check("mid_busy_pre", busy, 1);
        rst = 1;
        cycle();
        rst = 0;
        check("mid_ovld", out_valid, 0);
        check("mid_busy", busy, 0);
        glog.delete();
        v0 = 1; d0 = 16'h00F0; s0 = 5'd4;
        v1 = 1; d1 = 16'h0F00; s1 = 5'd8;
        cycle();
        check("mid_first", (glog.size() == 1) ? glog[0] : -1, 0);
        drain();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199, 0) == 0) begin
                rst = 1; v0 = 0; v1 = 0;
            end else begin
                rst = 0;
                if (!v0 && $urandom_range(2, 0) == 0) begin
                    v0 = 1; d0 = 16'($urandom); s0 = rand_shamt();
                end
                if (!v1 && $urandom_range(2, 0) == 0) begin
                    v1 = 1; d1 = 16'($urandom); s1 = rand_shamt();
                end
            end
            ordy = ($urandom_range(3, 0) != 0);
            cycle();
        end
        rst = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter OPERAND_WIDTH, default 16: operand and result width.
REQ-002 Parameter SHAMT_WIDTH, default 5: request shift-amount width (0..31).
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req0_valid, input, 1: requester 0 presents an operation.
REQ-006 Port req0_ready, output, 1: requester 0 operation accepted this cycle.
REQ-007 Port req0_data, input, OPERAND_WIDTH: requester 0 operand.
REQ-008 Port req0_shamt, input, SHAMT_WIDTH: requester 0 arithmetic-right shift amount.
REQ-009 Ports req1_valid, req1_ready, req1_data and req1_shamt: requester 1, same widths and meanings as requester 0.
REQ-010 Port out_valid, output, 1: result available.
REQ-011 Port out_ready, input, 1: consumer takes result.
REQ-012 Port out_data, output, OPERAND_WIDTH: arithmetic-right-shifted result.
REQ-013 Port out_id, output, 1: requester index owning out_data.
REQ-014 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 States: IDLE, SHIFT, DONE; one operation in flight at a time.
REQ-016 IDLE: if any reqN_valid, grant exactly one requester, with reqN_ready=1 combinationally for that requester only.
- On grant, capture data, shamt and id into internal registers; next state is SHIFT.
REQ-017 Arbitration is round-robin.
- Both valid: grant the requester not granted last.
- One valid: grant it.
- The last-grant pointer updates only on a grant.
REQ-018 reqN_ready SHALL be 0 in SHIFT and DONE, and 0 for the non-granted requester.
REQ-019 SHIFT, one pass per cycle through a 16-bit/4-bit arithmetic-right barrel shifter:
- pass amount = min(remaining, 15);
- operand register <= shifter result;
- remaining <= remaining - pass amount.
REQ-020 SHIFT exits to DONE when the post-pass remaining is 0, otherwise it stays in SHIFT.
- Passes: shamt 0..15 takes 1 pass; 16..30 takes 2; 31 takes 3.
- shamt 0 still takes one pass with amount 0.
REQ-021 Latency: a grant at cycle T gives out_valid=1 at T+1+passes.
REQ-022 DONE: out_valid=1, and out_data and out_id held stable until out_ready=1.
- On out_valid&out_ready, next state is IDLE; no new grant occurs in that same cycle.
REQ-023 Result equals the sign-extending arithmetic right shift of the original operand by shamt.
- shamt >= 15 yields all bits equal to the operand MSB.
REQ-024 Request inputs are ignored outside IDLE; a requester holds valid/data until it sees ready.

Reset
REQ-025 rst=1 in any state, including mid-SHIFT or DONE, forces IDLE on the next edge.
- The in-flight operation is discarded.
- Outputs after reset: out_valid=0, out_data=0, out_id=0, busy=0, req0_ready=req1_ready=0.
- The last-grant pointer resets to 1, so requester 0 wins the first contention.

Structure
REQ-026 The following belong in a shared package/include, with no local duplicates: state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), the max per-pass amount (15) and the width defaults.
REQ-027 One sub-module: shift_right_arthimetic, instantiated once with 16-bit operand and 4-bit amount, as the sole shift datapath.

Verification
REQ-028 After reset, req0 only: data=16'h8001, shamt=1 -> req0_ready at grant, out_valid 2 cycles later, out_data=16'hC000, out_id=0.
REQ-029 Both valid after reset, out_ready=1:
- first grant to req0, second to req1, third to req0;
- req1 data=16'h7FF0, shamt=4 -> 16'h07FF, out_id=1.
REQ-030 data=16'h8000, shamt=31 -> three SHIFT cycles, out_data=16'hFFFF.
REQ-031 data=16'h4000, shamt=16 -> two passes, out_data=16'h0000.
REQ-032 out_ready=0 for 5 cycles in DONE:
- out_data and out_id stay stable;
- no reqN_ready is asserted;
- release then returns to IDLE.
REQ-033 rst asserted mid-SHIFT (shamt=31) -> next cycle IDLE, out_valid=0, busy=0, and req0 wins the next contention.
